// File: rtl/seg_scan_driver.sv
// Time-multiplexed four-digit 7-segment scanner with guard blanking and a frame-latched shadow.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 4096,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [27:0] seg_in,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  cathode,
  output logic        frame_tick
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GUARD_L  = DW'(GUARD);

  logic [DW-1:0] div_cnt_reg;
  logic [1:0]    dig_reg;
  logic [27:0]   shadow_reg;
  logic [3:0]    an_reg;
  logic [6:0]    cathode_reg;
  logic          frame_tick_reg;

  logic          slot_end;
  logic          frame_end;
  logic          in_guard;
  logic          blank;
  logic [6:0]    field_sel;
  logic [6:0]    fields [4];
  logic [3:0]    an_next;
  logic [6:0]    cathode_next;

  // Digit 0 is the leftmost field, i.e. the top seven bits of the shadow.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      assign fields[gi] = shadow_reg[27-7*gi -: 7];
    end
  endgenerate

  assign field_sel = fields[dig_reg];
  assign slot_end  = (div_cnt_reg == DIV_LAST);
  assign frame_end = slot_end && (dig_reg == 2'd3);
  assign in_guard  = (div_cnt_reg < GUARD_L);

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frm_cnt_reg;
  logic          phase_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frm_cnt_reg <= '0;
      phase_reg   <= 1'b1;
    end else if (frame_end) begin
      if (frm_cnt_reg == FRM_LAST) begin
        frm_cnt_reg <= '0;
        phase_reg   <= ~phase_reg;
      end else begin
        frm_cnt_reg <= frm_cnt_reg + FW'(1);
      end
    end
  end

  assign blank = blink_mask[2'd3 - dig_reg] & ~phase_reg;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blank        = 1'b0;
`endif

  // The anode stays driven for a blanked digit; only the guard turns it off.
  always_comb begin
    an_next      = 4'hF;
    cathode_next = 7'h7F;
    if (!in_guard) begin
      an_next = ~(4'b1000 >> dig_reg);
      if (!blank) cathode_next = ~field_sel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg    <= '0;
      dig_reg        <= 2'd0;
      shadow_reg     <= '0;
      an_reg         <= 4'hF;
      cathode_reg    <= 7'h7F;
      frame_tick_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= slot_end ? '0 : div_cnt_reg + DW'(1);
      if (slot_end) dig_reg <= dig_reg + 2'd1;
      if (frame_end) shadow_reg <= seg_in;
      frame_tick_reg <= frame_end;
      an_reg         <= an_next;
      cathode_reg    <= cathode_next;
    end
  end

  assign an         = an_reg;
  assign cathode    = cathode_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

- Downstream display stage of the alarm clock.
- Takes the 28-bit four-digit segment pattern produced by the number-to-segment conversion and time-multiplexes it onto the board's shared-cathode 7-segment display.
- Each digit is driven in turn through active-low anodes with a guard blanking interval.
- A shadow register updates only at frame boundaries, so a digit never tears mid-frame.
- Selected digits can blink; the edit mode uses this to mark the digit under adjustment.

## Interface
Parameters:
- SCAN_DIV, 4096: clock cycles per digit slot; must be ≥ 2.
- GUARD, 16: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64: frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1: system clock; all state changes on its rising edge.
- resetn  in  1: reset, asynchronous, active-low.
- seg_in  in  28: {seg1, seg2, seg3, seg4}, seg1 is the leftmost digit; each 7-bit field is {g,f,e,d,c,b,a}, 1 = segment lit.
- blink_mask  in  4: bit 3 is the leftmost digit; 1 = digit blinks.
- an  out  4: digit anodes, active-low; bit 3 is the leftmost digit.
- cathode  out  7: {g,f,e,d,c,b,a}, active-low.
- frame_tick  out  1: one-cycle pulse when the shadow register loads.

## Operation
State registers:
- div_cnt: 0..SCAN_DIV-1.
- dig: 0..3, 0 = leftmost digit.
- shadow: 28 bits.
- frm_cnt: 0..BLINK_FRAMES-1.
- phase: 1 = visible.

Per cycle:
- div_cnt increments by 1.
- At SCAN_DIV-1, div_cnt wraps to 0 and dig advances modulo 4 (3→0).
- Frame boundary (div_cnt==SCAN_DIV-1 and dig==3):
  - shadow <= seg_in;
  - frame_tick <= 1 for exactly one cycle;
  - if frm_cnt==BLINK_FRAMES-1: frm_cnt <= 0 and phase toggles; otherwise frm_cnt increments.
- seg_in and blink_mask changes between frame boundaries have no effect on shadow. blink_mask is sampled combinationally per slot and is not shadowed.

Output decode, from current state:
- If div_cnt < GUARD: an = 4'b1111, cathode = 7'h7F.
- Otherwise an = all ones except bit (3-dig) = 0.
- cathode = ~shadow field for dig (dig 0 → shadow[27:21], dig 3 → shadow[6:0]).
- Blanked digit: cathode forced to 7'h7F, anode still driven.

Reset:
- resetn low forces div_cnt=0, dig=0, shadow=0, frm_cnt=0, phase=1.
- Outputs during reset: an=4'b1111, cathode=7'h7F, frame_tick=0.
- Reset mid-slot or mid-frame discards all progress. The first frame after release displays blank, since shadow is 0.

## Timing
- Outputs are registered: an/cathode at edge t+1 reflect state at edge t (1-cycle latency).
- Slot length is SCAN_DIV cycles; frame length is 4·SCAN_DIV cycles.
- First frame_tick occurs on the 4·SCAN_DIV-th rising edge after resetn rises. Loaded shadow data appears on an/cathode from the next visible slot of dig 0.
- Blink period is 2·BLINK_FRAMES frames; phase changes only at frame boundaries.
- Asynchronous reset takes effect immediately on outputs without waiting for clk. Deassertion is synchronised externally.
- seg_in is sampled only in the frame-boundary cycle; the producer needs no handshake.

## Configuration
- SEG_BLINK_EN defined:
  - blink logic is compiled in;
  - a digit with blink_mask bit set is blanked while phase==0.
- SEG_BLINK_EN undefined:
  - frm_cnt and phase are removed;
  - blink_mask is ignored;
  - all digits are always visible per the decode above.

## Test plan
SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2, SEG_BLINK_EN defined unless stated.
- Reset: hold resetn=0 with seg_in all ones and clk running → an=1111, cathode=1111111, frame_tick=0 throughout.
- Load "1234": seg_in={0000110,1011011,1001111,1100110}, release reset.
  - frame_tick pulses at edge 16.
  - Next visible slots show an=0111/cathode=1111001, an=1011/0100100, an=1101/0110000, an=1110/0011001.
  - Each slot is preceded by 1 cycle of an=1111.
- Tear-free update: change seg_in to "5678" during dig 1 of a frame → remaining slots still show "1234"; "5678" appears only after the next frame_tick.
- Blink: blink_mask=1000 → leftmost digit cathode=1111111 for 2 frames, then normal for 2 frames, repeating. Other digits are unaffected.
- Mid-operation reset: assert resetn=0 during dig 2 visible slot → an=1111 without a clk edge. After release, the scan restarts at dig 0 with a blank display until the first frame_tick.
- SEG_BLINK_EN undefined, blink_mask=1111 → all four digits continuously visible over 8 frames.
